// File: rtl/hpdmc_rdcapture_ctl.sv
// hpdmc_rdcapture_ctl
// -------------------
// Read-capture sequencer for the 16-bit DDR SDRAM PHY.
//
// For every READ command it opens a two-cycle capture window on the input
// DDR registers (via iddr_ce), L cycles after the command. It then glues the
// two captured beats together into one 4*DQ_W burst word for the HPDMC read
// datapath.
//
// Ports:
//   sys_clk      system clock (C0 of the capture registers)
//   sys_rst_n    asynchronous active-low reset, synchronous release
//   cl           programmed read latency, sampled on each read_issue
//   read_issue   one-cycle pulse: READ driven on the DDR bus this cycle
//   iddr_ce      registered clock enable for all capture registers
//   q0, q1       capture-register rising / falling edge outputs
//   rd_data      assembled burst {beat0.q0, beat0.q1, beat1.q0, beat1.q1}
//   rd_valid     one-cycle strobe: rd_data holds a complete burst
//   read_pending a read is scheduled or still being assembled
//   overrun      sticky: a read_issue collided with an occupied slot
//   err_clr      synchronous clear of overrun
//
// Schedule encoding: slot_q[j] means "iddr_ce is high j cycles from now",
// so slot_q[0] is the current iddr_ce. first_q marks the first slot of each
// read so the assembly side knows which beat it is looking at. Because the
// latency is encoded by slot position, every read in flight keeps its own
// latency even if cl changes afterwards.

module hpdmc_rdcapture_ctl #(
    parameter int DQ_W   = 16,
    parameter int CL_MIN = 2,
    parameter int CL_MAX = 7
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [2:0]        cl,
    input  logic              read_issue,
    output logic              iddr_ce,
    input  logic [DQ_W-1:0]   q0,
    input  logic [DQ_W-1:0]   q1,
    output logic [4*DQ_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              read_pending,
    output logic              overrun,
    input  logic              err_clr
);

    localparam int DEPTH = CL_MAX + 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  slot_q;
    logic [DEPTH-1:0]  first_q;
    logic [DEPTH-1:0]  slot_shift;
    logic [DEPTH-1:0]  first_shift;
    logic [DEPTH-1:0]  new_first;
    logic [DEPTH-1:0]  new_mask;
    logic [DEPTH-1:0]  slot_next;
    logic [DEPTH-1:0]  first_next;
    logic [LW-1:0]     lat;
    logic              collide;
    logic              accept;

    logic              cap_valid_q;
    logic              cap_first_q;
    logic [2*DQ_W-1:0] beat0_q;

    // Effective latency and schedule update. The schedule is shifted first
    // and the new read is tested against the post-shift view, so a slot that
    // is leaving this cycle never causes a false collision. In the shifted
    // frame bit j is the cycle T+1+j, hence the first new slot sits at L-1.
    always_comb begin
        if (int'(cl) < CL_MIN) begin
            lat = LW'(CL_MIN);
        end else if (int'(cl) > CL_MAX) begin
            lat = LW'(CL_MAX);
        end else begin
            lat = LW'(cl);
        end

        slot_shift  = slot_q >> 1;
        first_shift = first_q >> 1;
        new_first   = DEPTH'(1) << (lat - LW'(1));
        new_mask    = new_first | (new_first << 1);
        collide     = |(slot_shift & new_mask);
        accept      = read_issue & ~collide;

        slot_next  = slot_shift;
        first_next = first_shift;
        if (accept) begin
            slot_next  = slot_shift | new_mask;
            first_next = first_shift | new_first;
        end
    end

    // Slot shift register plus the sticky overrun flag. A collision in the
    // same cycle as err_clr keeps overrun set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_q  <= '0;
            first_q <= '0;
            overrun <= 1'b0;
        end else begin
            slot_q  <= slot_next;
            first_q <= first_next;
            if (read_issue && collide) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Beat pipeline. The capture registers add one cycle, so the beat
    // enabled in cycle c appears on q0/q1 in cycle c+1; cap_valid_q and
    // cap_first_q are the enable and beat index delayed to line up with it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cap_valid_q <= 1'b0;
            cap_first_q <= 1'b0;
            beat0_q     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            cap_valid_q <= slot_q[0];
            cap_first_q <= first_q[0];
            rd_valid    <= 1'b0;
            if (cap_valid_q && cap_first_q) begin
                beat0_q <= {q0, q1};
            end
            if (cap_valid_q && !cap_first_q) begin
                rd_data  <= {beat0_q, q0, q1};
                rd_valid <= 1'b1;
            end
        end
    end

    assign iddr_ce      = slot_q[0];
    assign read_pending = (|slot_q) | cap_valid_q | rd_valid;

endmodule
